// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled 8N1 serial receiver with a one-byte valid/ready output buffer
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous active-high reset
//   RXD       in   serial line, idle high, asynchronous to Clk
//   RX_Data   out  received byte, LSB received first
//   RX_Valid  out  RX_Data holds an unconsumed byte
//   RX_Ready  in   consumer accepts the byte when RX_Valid & RX_Ready at a rising edge
//   Frame_Err out  one-cycle pulse, stop bit sampled low
//   Overrun   out  one-cycle pulse, byte dropped because the buffer was full
//   Busy      out  receiver FSM is not idle
module uart_rx_core #(
    parameter int FREQ_CLK = 100000000,
    parameter int TX_SPEED = 115200
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RXD,
    output logic [7:0] RX_Data,
    output logic       RX_Valid,
    input  logic       RX_Ready,
    output logic       Frame_Err,
    output logic       Overrun,
    output logic       Busy
);
    localparam int BIT_CYCLES  = FREQ_CLK / TX_SPEED;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    if (BIT_CYCLES < 4) begin : g_bit_cycles_check
        $error("uart_rx_core: FREQ_CLK/TX_SPEED must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RXD};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~RX_Ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxd_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rxd_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                state_d = rxd_s ? IDLE : BREAK;
                ferr_d  = ~rxd_s;
                // a byte being accepted on this same edge frees the buffer for the new one
                if (rxd_s && (!valid_q || RX_Ready)) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else if (rxd_s) begin
                    ovr_d = 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy      = state_q != IDLE;
        RX_Data   = data_q;
        RX_Valid  = valid_q;
        Frame_Err = ferr_q;
        Overrun   = ovr_q;
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized self-checking bench for uart_rx_core against a byte-level line model
module tb_uart_rx_core;
    localparam int FREQ = 1600;
    localparam int BAUD = 100;
    localparam int BIT  = FREQ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int LAT  = 2 + HALF + 9 * BIT;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RXD = 1'b1;
    logic       RX_Ready = 1'b0;
    logic [7:0] RX_Data;
    logic       RX_Valid, Frame_Err, Overrun, Busy;

    uart_rx_core #(.FREQ_CLK(FREQ), .TX_SPEED(BAUD)) dut (
        .Clk(Clk), .Rst(Rst), .RXD(RXD), .RX_Data(RX_Data), .RX_Valid(RX_Valid),
        .RX_Ready(RX_Ready), .Frame_Err(Frame_Err), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0, passed = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0, vh_cnt = 0, stab_err = 0, rise_cyc = 0, start_cyc = 0;
    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] got[$];

    // observe one settled sample per cycle; an accept happened at the edge just passed
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (Rst) pv = 1'b0;
        else begin
            if (Frame_Err) fe_cnt++;
            if (Overrun) ov_cnt++;
            if (RX_Valid) vh_cnt++;
            if (pv && RX_Ready) got.push_back(pd);
            else if (pv && (!RX_Valid || RX_Data !== pd)) stab_err++;
            if (RX_Valid && !pv) rise_cyc = cyc;
            pv = RX_Valid;
            pd = RX_Data;
        end
    end

    task automatic send_bits(input logic [7:0] b);
        RXD = 1'b0;
        start_cyc = cyc + 1;
        repeat (BIT) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BIT) @(negedge Clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        send_bits(b);
        RXD = stop;
        repeat (BIT) @(negedge Clk);
        RXD = 1'b1;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if ({RX_Data, RX_Valid, Frame_Err, Overrun, Busy} !== 12'h000)
            $display("FAIL reset_outputs got=%h want=000", {RX_Data, RX_Valid, Frame_Err, Overrun, Busy});
        else passed++;
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_single();
        int fe0 = fe_cnt, ov0 = ov_cnt, vh0 = vh_cnt, lat;
        RX_Ready = 1'b1;
        got.delete();
        send_frame(8'hAA, 1'b1, 4);
        lat = rise_cyc - start_cyc;
        checks++;
        if (got.size() != 1 || got[0] !== 8'hAA)
            $display("FAIL single_data got_n=%0d got=%h want=aa", got.size(), got.size() ? got[0] : 8'hxx);
        else passed++;
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) $display("FAIL single_latency got=%0d want=%0d", lat, LAT);
        else passed++;
        checks++;
        if (vh_cnt - vh0 != 1) $display("FAIL single_valid_pulse got=%0d want=1", vh_cnt - vh0);
        else passed++;
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0)
            $display("FAIL single_no_err got_fe=%0d got_ov=%0d want=0", fe_cnt - fe0, ov_cnt - ov0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ov0 = ov_cnt;
        RX_Ready = 1'b0;
        got.delete();
        send_frame(8'h03, 1'b1, 0);
        send_frame(8'hCC, 1'b1, 4);
        checks++;
        if (ov_cnt - ov0 != 1) $display("FAIL b2b_overrun got=%0d want=1", ov_cnt - ov0);
        else passed++;
        checks++;
        if ({RX_Valid, RX_Data} !== {1'b1, 8'h03}) $display("FAIL b2b_held got=%h want=103", {RX_Valid, RX_Data});
        else passed++;
        RX_Ready = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({RX_Valid, RX_Data} !== {1'b0, 8'h03}) $display("FAIL b2b_drain got=%h want=003", {RX_Valid, RX_Data});
        else passed++;
        checks++;
        if (got.size() != 1 || got[0] !== 8'h03)
            $display("FAIL b2b_accepted got_n=%0d got=%h want=03", got.size(), got.size() ? got[0] : 8'hxx);
        else passed++;
    endtask

    task automatic test_frame_err();
        int fe0 = fe_cnt, vh0 = vh_cnt;
        RX_Ready = 1'b1;
        got.delete();
        send_bits(8'h55);
        RXD = 1'b0;
        repeat (4 * BIT) @(negedge Clk);
        checks++;
        if (fe_cnt - fe0 != 1) $display("FAIL ferr_count got=%0d want=1", fe_cnt - fe0);
        else passed++;
        checks++;
        if (Busy !== 1'b1) $display("FAIL ferr_busy_break got=%b want=1", Busy);
        else passed++;
        RXD = 1'b1;
        repeat (4) @(negedge Clk);
        checks++;
        if ({Busy, vh_cnt - vh0} !== {1'b0, 32'd0}) $display("FAIL ferr_idle got_busy=%b got_valid=%0d want=0", Busy, vh_cnt - vh0);
        else passed++;
        send_frame(8'h5A, 1'b1, 4);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h5A)
            $display("FAIL ferr_recover got_n=%0d got=%h want=5a", got.size(), got.size() ? got[0] : 8'hxx);
        else passed++;
    endtask

    task automatic test_false_start();
        int fe0 = fe_cnt, ov0 = ov_cnt, vh0 = vh_cnt;
        RXD = 1'b0;
        repeat (3) @(negedge Clk);
        RXD = 1'b1;
        checks++;
        if (Busy !== 1'b1) $display("FAIL glitch_start got=%b want=1", Busy);
        else passed++;
        repeat (2 * HALF + 4) @(negedge Clk);
        checks++;
        if ({Busy, fe_cnt - fe0, ov_cnt - ov0, vh_cnt - vh0} !== {1'b0, 96'd0})
            $display("FAIL glitch_idle got_busy=%b fe=%0d ov=%0d valid=%0d want=0", Busy, fe_cnt - fe0, ov_cnt - ov0, vh_cnt - vh0);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] b = 8'h81;
        int fe0 = fe_cnt, ov0 = ov_cnt;
        RX_Ready = 1'b1;
        got.delete();
        RXD = 1'b0;
        repeat (BIT) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            RXD = b[i];
            repeat (i == 4 ? HALF : BIT) @(negedge Clk);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if ({RX_Data, RX_Valid, Frame_Err, Overrun, Busy} !== 12'h000)
            $display("FAIL midreset_outputs got=%h want=000", {RX_Data, RX_Valid, Frame_Err, Overrun, Busy});
        else passed++;
        RXD = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        send_frame(8'h7E, 1'b1, 4);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h7E)
            $display("FAIL midreset_data got_n=%0d got=%h want=7e", got.size(), got.size() ? got[0] : 8'hxx);
        else passed++;
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL midreset_err got_fe=%0d got_ov=%0d want=0", fe_cnt - fe0, ov_cnt - ov0);
        else passed++;
    endtask

    task automatic test_accept_on_stop();
        int ov0 = ov_cnt;
        RX_Ready = 1'b0;
        got.delete();
        send_frame(8'h11, 1'b1, 4);
        send_bits(8'h22);
        RXD = 1'b1;
        repeat (HALF + 2) @(negedge Clk);
        RX_Ready = 1'b1;
        @(negedge Clk);
        RX_Ready = 1'b0;
        repeat (BIT - HALF - 3 + 4) @(negedge Clk);
        checks++;
        if (ov_cnt != ov0) $display("FAIL same_edge_overrun got=%0d want=0", ov_cnt - ov0);
        else passed++;
        checks++;
        if ({RX_Valid, RX_Data} !== {1'b1, 8'h22}) $display("FAIL same_edge_data got=%h want=122", {RX_Valid, RX_Data});
        else passed++;
        RX_Ready = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22)
            $display("FAIL same_edge_order got_n=%0d want=2 (11,22)", got.size());
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        int fe0 = fe_cnt, efe = 0;
        RX_Ready = 1'b1;
        got.delete();
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b = 8'($urandom);
            logic bad = $urandom_range(0, 3) == 0;
            send_frame(b, ~bad, $urandom_range(1, 6));
            if (bad) efe++;
            else exp.push_back(b);
        end
        checks++;
        if (got.size() != exp.size()) $display("FAIL rand_count got=%0d want=%0d", got.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) $display("FAIL rand_byte%0d got=%h want=%h", i, got[i], exp[i]);
            else passed++;
        end
        checks++;
        if (fe_cnt - fe0 != efe) $display("FAIL rand_ferr got=%0d want=%0d", fe_cnt - fe0, efe);
        else passed++;
        checks++;
        if (stab_err != 0) $display("FAIL hold_stability got=%0d want=0", stab_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_false_start();
        test_mid_reset();
        test_accept_on_stop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
